// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter -- writeback arbiter in front of the register set write port.
//
// Merges single-cycle ALU results (no backpressure) and handshaked LSU
// results (loads / divides) onto one registered write port. LSU results that
// lose the port to the ALU are parked in a small FIFO. A younger ALU write to
// the same register squashes any older buffered LSU result for it, so the
// register set never sees an older value land after a newer one.
//
// Optional build macro:
//   WB_FORWARD_EN  - enables same-cycle forwarding of the output stage to the
//                    two operand read addresses. Without it the fwd* outputs
//                    are tied to zero and q0_reg/q1_reg are ignored.
//
// Ports:
//   clk           clock, rising edge
//   res           asynchronous active-high reset
//   alu_valid     ALU result present this cycle
//   alu_reg       ALU destination register
//   alu_data      ALU result
//   lsu_valid     LSU result offered
//   lsu_ready     LSU result accepted when lsu_valid && lsu_ready
//   lsu_reg       LSU destination register
//   lsu_data      LSU result
//   write         register set write data (registered)
//   write_reg     register set write address (registered)
//   write_enable  register set write enable (registered)
//   pending       number of live (unsquashed) buffered LSU results
//   q0_reg/q1_reg operand read addresses mirrored from the register set
//   fwd0/1_hit    forward valid for q0/q1
//   fwd0/1_data   forwarded data
// ============================================================================

`ifndef REGISTER_COUNT
`define REGISTER_COUNT 32
`endif

module wb_arbiter #(
    parameter int FIFO_DEPTH     = 4,
    parameter int REGISTER_COUNT = `REGISTER_COUNT,
    parameter int DATA_WIDTH     = 32,
    localparam int RW            = $clog2(REGISTER_COUNT),
    localparam int PW            = $clog2(FIFO_DEPTH),
    localparam int CW            = PW + 1
) (
    input  logic                  clk,
    input  logic                  res,

    input  logic                  alu_valid,
    input  logic [RW-1:0]         alu_reg,
    input  logic [DATA_WIDTH-1:0] alu_data,

    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [RW-1:0]         lsu_reg,
    input  logic [DATA_WIDTH-1:0] lsu_data,

    output logic [DATA_WIDTH-1:0] write,
    output logic [RW-1:0]         write_reg,
    output logic                  write_enable,
    output logic [CW-1:0]         pending,

    input  logic [RW-1:0]         q0_reg,
    input  logic [RW-1:0]         q1_reg,
    output logic                  fwd0_hit,
    output logic                  fwd1_hit,
    output logic [DATA_WIDTH-1:0] fwd0_data,
    output logic [DATA_WIDTH-1:0] fwd1_data
);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [RW-1:0]         fifo_reg_mem  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];

    // Per-slot live flag. Slots outside the occupied window are always 0,
    // so the popcount of this vector is the live entry count.
    logic [FIFO_DEPTH-1:0] entry_valid_reg;
    logic [FIFO_DEPTH-1:0] entry_valid_next;

    // Pointers carry one extra bit to tell full from empty.
    logic [PW:0]           wr_ptr_reg;
    logic [PW:0]           rd_ptr_reg;
    logic [PW-1:0]         wr_idx;
    logic [PW-1:0]         rd_idx;

    logic [DATA_WIDTH-1:0] write_data_reg;
    logic [RW-1:0]         write_reg_reg;
    logic                  write_enable_reg;
    logic [CW-1:0]         pending_reg;
    logic [CW-1:0]         pending_next;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  alu_take;
    logic                  lsu_fire;
    logic                  lsu_keep;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic                  head_live;
    logic                  head_write;
    logic [FIFO_DEPTH-1:0] squash_hit;

    logic                  write_enable_next;
    logic [RW-1:0]         sel_reg;
    logic [DATA_WIDTH-1:0] sel_data;

    assign wr_idx     = wr_ptr_reg[PW-1:0];
    assign rd_idx     = rd_ptr_reg[PW-1:0];
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                        (wr_idx == rd_idx);

    // Full is physical occupancy (squashed entries still hold a slot until
    // popped), and is taken from registered pointers only: a pop this cycle
    // does not reopen the input until the next cycle.
    assign lsu_ready  = !fifo_full;

    assign alu_take   = alu_valid && (alu_reg != '0);
    assign lsu_fire   = lsu_valid && lsu_ready;

    // An accepted LSU result survives only if it targets a real register and
    // is not overtaken by the ALU writing the same register this cycle.
    assign lsu_keep   = lsu_fire && (lsu_reg != '0) &&
                        !(alu_take && (alu_reg == lsu_reg));

    // Bypass only when nothing is buffered, so FIFO order is never violated.
    assign bypass     = lsu_keep && fifo_empty && !alu_take;
    assign push       = lsu_keep && !bypass;

    // head_live uses the registered flag: a head squashed by the ALU this
    // cycle loses to the ALU anyway and is discarded on a later cycle.
    assign head_live  = !fifo_empty && entry_valid_reg[rd_idx];
    assign head_write = head_live && !alu_take;

    // A dead head is discarded alongside whatever else uses the port; a live
    // head leaves only when it actually gets the port.
    assign pop        = !fifo_empty && (!entry_valid_reg[rd_idx] || !alu_take);

    // ------------------------------------------------------------------
    // Per-entry squash and live flag update
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            assign squash_hit[gi] = alu_take && (fifo_reg_mem[gi] == alu_reg);

            always_comb begin
                entry_valid_next[gi] = entry_valid_reg[gi];
                if (squash_hit[gi]) begin
                    entry_valid_next[gi] = 1'b0;
                end
                if (pop && (rd_idx == PW'(gi))) begin
                    entry_valid_next[gi] = 1'b0;
                end
                // The push slot is free, so it cannot collide with a pop, and
                // lsu_keep already excludes a same-register ALU write.
                if (push && (wr_idx == PW'(gi))) begin
                    entry_valid_next[gi] = 1'b1;
                end
            end
        end
    endgenerate

    function automatic logic [CW-1:0] count_live(input logic [FIFO_DEPTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    assign pending_next = count_live(entry_valid_next);

    // ------------------------------------------------------------------
    // Port selection: ALU, then FIFO head, then LSU bypass.
    // ------------------------------------------------------------------
    always_comb begin
        write_enable_next = 1'b0;
        sel_reg           = write_reg_reg;
        sel_data          = write_data_reg;
        if (alu_take) begin
            write_enable_next = 1'b1;
            sel_reg           = alu_reg;
            sel_data          = alu_data;
        end else if (head_write) begin
            write_enable_next = 1'b1;
            sel_reg           = fifo_reg_mem[rd_idx];
            sel_data          = fifo_data_mem[rd_idx];
        end else if (bypass) begin
            write_enable_next = 1'b1;
            sel_reg           = lsu_reg;
            sel_data          = lsu_data;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Payload storage carries no reset; its content is qualified by the
    // live flags and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg_mem[wr_idx]  <= lsu_reg;
            fifo_data_mem[wr_idx] <= lsu_data;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            entry_valid_reg  <= '0;
            pending_reg      <= '0;
            write_enable_reg <= 1'b0;
            write_reg_reg    <= '0;
            write_data_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            entry_valid_reg  <= entry_valid_next;
            pending_reg      <= pending_next;
            write_enable_reg <= write_enable_next;
            // Address/data hold when idle so the port does not toggle.
            if (write_enable_next) begin
                write_reg_reg  <= sel_reg;
                write_data_reg <= sel_data;
            end
        end
    end

    assign write        = write_data_reg;
    assign write_reg    = write_reg_reg;
    assign write_enable = write_enable_reg;
    assign pending      = pending_reg;

    // ------------------------------------------------------------------
    // Operand forwarding: covers the gap between the register set write
    // and a read of the same register in the same cycle.
    // ------------------------------------------------------------------
`ifdef WB_FORWARD_EN
    assign fwd0_hit  = write_enable_reg && (write_reg_reg == q0_reg) && (q0_reg != '0);
    assign fwd1_hit  = write_enable_reg && (write_reg_reg == q1_reg) && (q1_reg != '0);
    assign fwd0_data = write_data_reg;
    assign fwd1_data = write_data_reg;
`else
    logic unused_q;
    assign unused_q  = ^{q0_reg, q1_reg};
    assign fwd0_hit  = 1'b0;
    assign fwd1_hit  = 1'b0;
    assign fwd0_data = '0;
    assign fwd1_data = '0;
`endif

endmodule
